matmul_seq: RTL and testbench

// - Sequences one dotprod pipeline over an M x N output tile, row-major.
// - Issues one (A-row, B-col) index pair per cycle and tracks in-flight results.
// - Tags each result with (row, col) and buffers it in an output FIFO with

---
 rtl/matmul_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_matmul_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq.sv
// matmul_seq: walks an M x N output tile row-major through one dotprod pipeline, tagging and buffering each result.
// Latency: first issue the cycle after start is accepted; a result reaches res_* DP_LAT+1 cycles after its issue.
// Backpressure: res_ready throttles issue through credits (FIFO slots minus in-flight); the dotprod never stalls.
// Build option: define MATSEQ_PERF_EN to add the perf_cycles/perf_stalls counters.

// Small result FIFO: first-word-fall-through head, simultaneous push/pop allowed at any fill level.
module matmul_seq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage is data-only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    // Pointers and fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module matmul_seq #(
    parameter int DATA_W     = 32,
    parameter int MAX_DIM    = 16,
    parameter int DP_LAT     = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W = ($clog2(MAX_DIM) > 1) ? $clog2(MAX_DIM) : 1,
    localparam int DIM_W = $clog2(MAX_DIM + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  m_rows,
    input  logic [DIM_W-1:0]  n_cols,
    output logic              busy,
    output logic              done,
`ifdef MATSEQ_PERF_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls,
`endif
    output logic              dp_issue,
    output logic [IDX_W-1:0]  a_row_idx,
    output logic [IDX_W-1:0]  b_col_idx,
    input  logic [DATA_W-1:0] dp_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [IDX_W-1:0]  res_row,
    output logic [IDX_W-1:0]  res_col
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int OCC_W = $clog2(FIFO_DEPTH + DP_LAT + 1) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } tag_t;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [IDX_W-1:0]  row;
        logic [IDX_W-1:0]  col;
    } res_t;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [DIM_W-1:0] m_lat;
    logic [DIM_W-1:0] n_lat;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    tag_t             sr [DP_LAT];
    logic [OCC_W-1:0] inflight;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push;
    logic             fifo_pop;
    res_t             fifo_in;
    res_t             fifo_head;
    logic             row_last;
    logic             col_last;
    logic             drain_done;
    logic             zero_dim;

    assign zero_dim = (m_rows == '0) || (n_cols == '0);
    assign row_last = (row == IDX_W'(m_lat - DIM_W'(1)));
    assign col_last = (col == IDX_W'(n_lat - DIM_W'(1)));

    // Count of results still travelling through the dotprod.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < DP_LAT; i++) inflight = inflight + OCC_W'(sr[i].vld);
    end

    // A head leaving on this edge frees its slot in time for the operand issued now,
    // which is what lets FIFO_DEPTH = DP_LAT+1 sustain one issue per cycle.
    assign occupancy = OCC_W'(fifo_count) + inflight - OCC_W'(fifo_pop);
    assign dp_issue  = (state == ST_RUN) && (occupancy < OCC_W'(FIFO_DEPTH));

    // DRAIN exits once the last result is leaving the FIFO on this edge, so done
    // follows the final accepted pop by exactly one cycle.
    assign drain_done = (inflight == '0) &&
                        ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop));

    // Next-state logic; an empty tile passes through DRAIN so done trails busy by a cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = zero_dim ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (dp_issue && row_last && col_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register and tile dimensions captured on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            m_lat <= '0;
            n_lat <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                m_lat <= m_rows;
                n_lat <= n_cols;
            end
        end
    end

    // Operand indices advance only on issue and return to (0,0) after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (dp_issue) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + IDX_W'(1);
            end else begin
                col <= col + IDX_W'(1);
            end
        end
    end

    // Tag pipeline matching the dotprod latency; the tail lines up with a valid dp_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DP_LAT; i++) sr[i] <= '0;
        end else begin
            sr[0] <= '{dp_issue, row, col};
            for (int i = 1; i < DP_LAT; i++) sr[i] <= sr[i-1];
        end
    end

    assign fifo_push = sr[DP_LAT-1].vld;
    assign fifo_in   = '{dp_out, sr[DP_LAT-1].row, sr[DP_LAT-1].col};
    assign fifo_pop  = res_valid && res_ready;

    matmul_seq_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (fifo_in),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .count    (fifo_count)
    );

    // Head fields are masked while empty so stale storage never reaches the port.
    assign res_valid = (fifo_count != '0);
    assign res_data  = res_valid ? fifo_head.dat : '0;
    assign res_row   = res_valid ? fifo_head.row : '0;
    assign res_col   = res_valid ? fifo_head.col : '0;

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign a_row_idx = row;
    assign b_col_idx = col;

`ifdef MATSEQ_PERF_EN
    // Tile cycle and issue-stall counters; cleared by start, held once idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state == ST_IDLE && start) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy) perf_cycles <= perf_cycles + 32'd1;
            if (state == ST_RUN && !dp_issue) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: scenario tasks against a row-major tile model and a fixed-delay dotprod model.
// Inputs change 1 ns after the rising edge; outputs are observed on the falling edge.
// res_ready is held, toggled or randomised per scenario to exercise credit backpressure.
`timescale 1ns/1ps
module tb_matmul_seq;
    localparam int DATA_W     = 32;
    localparam int MAX_DIM    = 16;
    localparam int DP_LAT     = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int IDX_W      = 4;
    localparam int DIM_W      = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  m_rows = '0;
    logic [DIM_W-1:0]  n_cols = '0;
    logic              busy, done, dp_issue, res_valid;
    logic [IDX_W-1:0]  a_row_idx, b_col_idx, res_row, res_col;
    logic [DATA_W-1:0] dp_out = '0;
    logic [DATA_W-1:0] res_data;
    logic              res_ready = 1'b1;
`ifdef MATSEQ_PERF_EN
    logic [31:0]       perf_cycles, perf_stalls;
`endif

    matmul_seq #(
        .DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .DP_LAT(DP_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .m_rows(m_rows), .n_cols(n_cols),
        .busy(busy), .done(done),
`ifdef MATSEQ_PERF_EN
        .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
`endif
        .dp_issue(dp_issue), .a_row_idx(a_row_idx), .b_col_idx(b_col_idx), .dp_out(dp_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_row(res_row), .res_col(res_col)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int row; int col; logic [31:0] dat; } ev_t;

    int checks = 0;
    int fails  = 0;

    ev_t         iss_q[$];
    ev_t         pop_q[$];
    int          done_q[$];
    int          cyc = 0;
    int          busy_cnt = 0;
    int          busy_first = -1;
    int          valid_cnt = 0;
    int          outstanding = 0;
    int          max_out = 0;
    logic [31:0] val [MAX_DIM][MAX_DIM];
    bit          dv [DP_LAT+1];
    int          dr [DP_LAT+1];
    int          dc [DP_LAT+1];

    // Dotprod model (fixed delay, result = table entry) plus event recorder.
    always @(negedge clk) begin
        cyc++;
        for (int i = DP_LAT; i > 0; i--) begin
            dv[i] = dv[i-1]; dr[i] = dr[i-1]; dc[i] = dc[i-1];
        end
        dv[0] = dp_issue; dr[0] = int'(a_row_idx); dc[0] = int'(b_col_idx);
        dp_out = dv[DP_LAT] ? val[dr[DP_LAT]][dc[DP_LAT]] : $urandom;
        if (dp_issue) begin
            iss_q.push_back('{cyc, int'(a_row_idx), int'(b_col_idx), 32'h0});
            outstanding++;
        end
        if (res_valid) valid_cnt++;
        if (res_valid && res_ready) begin
            pop_q.push_back('{cyc, int'(res_row), int'(res_col), res_data});
            outstanding--;
        end
        if (outstanding > max_out) max_out = outstanding;
        if (busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_cnt++;
        end
        if (done) done_q.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        iss_q.delete(); pop_q.delete(); done_q.delete();
        busy_cnt = 0; busy_first = -1; valid_cnt = 0; outstanding = 0; max_out = 0;
    endtask

    task automatic new_vals();
        for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < MAX_DIM; c++) val[r][c] = $urandom;
    endtask

    task automatic start_tile(input int m, input int n);
        tick();
        start = 1'b1; m_rows = DIM_W'(m); n_cols = DIM_W'(n);
        tick();
        start = 1'b0;
    endtask

    // mode 0: hold res_ready, 1: toggle every cycle, 2: random every cycle.
    task automatic run_until_done(input int budget, input int mode, output bit to);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            tick();
            n++;
            if (mode == 1)      res_ready = ~res_ready;
            else if (mode == 2) res_ready = 1'($urandom_range(0, 1));
        end
        to = (done_q.size() == 0);
        tick();
        tick();
        res_ready = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy, done, dp_issue, res_valid, a_row_idx, b_col_idx, res_row, res_col, res_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b issue=%b valid=%b idx=%0d/%0d tag=%0d/%0d data=%h, expected all zero",
                     busy, done, dp_issue, res_valid, a_row_idx, b_col_idx, res_row, res_col, res_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit to;
        int er, ec;
        clear_rec(); new_vals(); res_ready = 1'b1;
        start_tile(2, 3);
        run_until_done(200, 0, to);
        checks++;
        if (to) begin fails++; $display("FAIL basic_timeout: no done within budget"); end
        checks++;
        if (iss_q.size() != 6) begin fails++; $display("FAIL basic_issue_count: got %0d expected 6", iss_q.size()); end
        for (int k = 0; k < iss_q.size() && k < 6; k++) begin
            er = k / 3; ec = k % 3;
            checks++;
            if (iss_q[k].cyc != iss_q[0].cyc + k || iss_q[k].row != er || iss_q[k].col != ec) begin
                fails++;
                $display("FAIL basic_issue_%0d: cyc+%0d (%0d,%0d), expected cyc+%0d (%0d,%0d)",
                         k, iss_q[k].cyc - iss_q[0].cyc, iss_q[k].row, iss_q[k].col, k, er, ec);
            end
        end
        checks++;
        if (pop_q.size() != 6) begin fails++; $display("FAIL basic_result_count: got %0d expected 6", pop_q.size()); end
        for (int k = 0; k < pop_q.size() && k < 6; k++) begin
            er = k / 3; ec = k % 3;
            checks++;
            if (pop_q[k].row != er || pop_q[k].col != ec || pop_q[k].dat !== val[er][ec]) begin
                fails++;
                $display("FAIL basic_result_%0d: (%0d,%0d) %h, expected (%0d,%0d) %h",
                         k, pop_q[k].row, pop_q[k].col, pop_q[k].dat, er, ec, val[er][ec]);
            end
        end
        checks++;
        if (done_q.size() != 1) begin fails++; $display("FAIL basic_done_count: got %0d expected 1", done_q.size()); end
        if (done_q.size() > 0 && iss_q.size() > 0) begin
            checks++;
            if (done_q[0] != iss_q[iss_q.size()-1].cyc + 5) begin
                fails++;
                $display("FAIL basic_done_timing: %0d cycles after last issue, expected 5",
                         done_q[0] - iss_q[iss_q.size()-1].cyc);
            end
        end
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_empty();
        bit to;
        int ms [2] = '{0, 3};
        int ns [2] = '{5, 0};
        for (int t = 0; t < 2; t++) begin
            clear_rec();
            start_tile(ms[t], ns[t]);
            run_until_done(20, 0, to);
            checks++;
            if (to || iss_q.size() != 0 || valid_cnt != 0) begin
                fails++;
                $display("FAIL empty_%0d_activity: timeout=%b issues=%0d valid_cycles=%0d, expected 0/0/0",
                         t, to, iss_q.size(), valid_cnt);
            end
            checks++;
            if (done_q.size() != 1 || done_q[0] != busy_first + 1) begin
                fails++;
                $display("FAIL empty_%0d_done: pulses=%0d at busy+%0d, expected 1 at busy+1",
                         t, done_q.size(), (done_q.size() > 0) ? done_q[0] - busy_first : -1);
            end
            checks++;
            if (busy_cnt != 2) begin fails++; $display("FAIL empty_%0d_busy: %0d cycles, expected 2", t, busy_cnt); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int er, ec;
        clear_rec(); new_vals(); res_ready = 1'b0;
        start_tile(4, 4);
        repeat (20) tick();
        @(negedge clk);
        checks++;
        if (iss_q.size() != FIFO_DEPTH) begin
            fails++; $display("FAIL bp_issue_count: got %0d expected %0d", iss_q.size(), FIFO_DEPTH);
        end
        checks++;
        if (dp_issue !== 1'b0) begin fails++; $display("FAIL bp_issue_stopped: got %b expected 0", dp_issue); end
        checks++;
        if (res_valid !== 1'b1 || res_row !== '0 || res_col !== '0 || res_data !== val[0][0]) begin
            fails++;
            $display("FAIL bp_head_held: valid=%b (%0d,%0d) %h, expected 1 (0,0) %h",
                     res_valid, res_row, res_col, res_data, val[0][0]);
        end
        tick();
        res_ready = 1'b1;
        run_until_done(300, 0, to);
        checks++;
        if (to) begin fails++; $display("FAIL bp_timeout: no done within budget"); end
        checks++;
        if (pop_q.size() != 16 || iss_q.size() != 16) begin
            fails++; $display("FAIL bp_counts: results=%0d issues=%0d, expected 16/16", pop_q.size(), iss_q.size());
        end
        for (int k = 0; k < pop_q.size() && k < 16; k++) begin
            er = k / 4; ec = k % 4;
            checks++;
            if (pop_q[k].row != er || pop_q[k].col != ec || pop_q[k].dat !== val[er][ec]) begin
                fails++;
                $display("FAIL bp_result_%0d: (%0d,%0d) %h, expected (%0d,%0d) %h",
                         k, pop_q[k].row, pop_q[k].col, pop_q[k].dat, er, ec, val[er][ec]);
            end
        end
        checks++;
        if (max_out > FIFO_DEPTH) begin fails++; $display("FAIL bp_overflow: %0d outstanding, limit %0d", max_out, FIFO_DEPTH); end
    endtask

    // First tile is the 3x3 alternating-ready case; the rest are random shapes and ready patterns.
    task automatic test_tiles();
        bit to;
        int m, n, er, ec, mode;
        for (int t = 0; t < 5; t++) begin
            if (t == 0) begin m = 3; n = 3; mode = 1; res_ready = 1'b1; end
            else begin m = int'($urandom_range(1, 6)); n = int'($urandom_range(1, 6)); mode = 2; end
            clear_rec(); new_vals();
            start_tile(m, n);
            run_until_done(600, mode, to);
            checks++;
            if (to || done_q.size() != 1 || iss_q.size() != m * n) begin
                fails++;
                $display("FAIL tile_%0d_%0dx%0d_counts: timeout=%b done=%0d issues=%0d, expected 0/1/%0d",
                         t, m, n, to, done_q.size(), iss_q.size(), m * n);
            end
            checks++;
            if (pop_q.size() != m * n) begin
                fails++; $display("FAIL tile_%0d_result_count: got %0d expected %0d", t, pop_q.size(), m * n);
            end
            for (int k = 0; k < pop_q.size() && k < m * n; k++) begin
                er = k / n; ec = k % n;
                checks++;
                if (pop_q[k].row != er || pop_q[k].col != ec || pop_q[k].dat !== val[er][ec]) begin
                    fails++;
                    $display("FAIL tile_%0d_result_%0d: (%0d,%0d) %h, expected (%0d,%0d) %h",
                             t, k, pop_q[k].row, pop_q[k].col, pop_q[k].dat, er, ec, val[er][ec]);
                end
            end
            if (done_q.size() > 0 && pop_q.size() > 0) begin
                checks++;
                if (pop_q[pop_q.size()-1].cyc != done_q[0] - 1) begin
                    fails++;
                    $display("FAIL tile_%0d_last_pop: at done%0d, expected done-1", t, pop_q[pop_q.size()-1].cyc - done_q[0]);
                end
            end
            checks++;
            if (max_out > FIFO_DEPTH) begin
                fails++; $display("FAIL tile_%0d_overflow: %0d outstanding, limit %0d", t, max_out, FIFO_DEPTH);
            end
        end
    endtask

    task automatic test_abort();
        bit to;
        clear_rec(); new_vals(); res_ready = 1'b1;
        start_tile(2, 2);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, dp_issue, res_valid, a_row_idx, b_col_idx, res_row, res_col, res_data} !== '0) begin
            fails++;
            $display("FAIL abort_reset_outputs: busy=%b done=%b issue=%b valid=%b idx=%0d/%0d tag=%0d/%0d data=%h, expected all zero",
                     busy, done, dp_issue, res_valid, a_row_idx, b_col_idx, res_row, res_col, res_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        clear_rec();
        repeat (15) tick();
        checks++;
        if (valid_cnt != 0 || done_q.size() != 0 || iss_q.size() != 0) begin
            fails++;
            $display("FAIL abort_quiet: valid_cycles=%0d done=%0d issues=%0d, expected 0/0/0",
                     valid_cnt, done_q.size(), iss_q.size());
        end
        new_vals();
        start_tile(1, 1);
        run_until_done(50, 0, to);
        checks++;
        if (to || done_q.size() != 1) begin
            fails++; $display("FAIL abort_restart_done: timeout=%b pulses=%0d, expected 0/1", to, done_q.size());
        end
        checks++;
        if (pop_q.size() != 1 || pop_q[0].row != 0 || pop_q[0].col != 0 || pop_q[0].dat !== val[0][0]) begin
            fails++;
            $display("FAIL abort_restart_result: count=%0d first=%h, expected 1 at (0,0) %h",
                     pop_q.size(), (pop_q.size() > 0) ? pop_q[0].dat : 32'h0, val[0][0]);
        end
    endtask

`ifdef MATSEQ_PERF_EN
    task automatic test_perf();
        bit to;
        int dims [2] = '{2, 3};
        int run_cyc, exp_stalls;
        for (int t = 0; t < 2; t++) begin
            clear_rec(); new_vals(); res_ready = 1'b0;
            start_tile(dims[t], dims[t]);
            repeat (9) tick();
            res_ready = 1'b1;
            run_until_done(200, 0, to);
            repeat (3) tick();
            run_cyc    = (iss_q.size() > 0) ? iss_q[iss_q.size()-1].cyc - busy_first + 1 : 0;
            exp_stalls = run_cyc - iss_q.size();
            checks++;
            if (to || perf_stalls !== 32'(exp_stalls)) begin
                fails++; $display("FAIL perf_%0d_stalls: got %0d expected %0d (timeout=%b)", t, perf_stalls, exp_stalls, to);
            end
            checks++;
            if (perf_cycles !== 32'(busy_cnt)) begin
                fails++; $display("FAIL perf_%0d_cycles: got %0d expected %0d", t, perf_cycles, busy_cnt);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_backpressure();
        test_tiles();
        test_abort();
`ifdef MATSEQ_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
